// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with a single req/ack memory port.
// Sequence: IDLE -> FETCH -> DECODE -> (MEM) -> EXEC -> FETCH ..., HALT is terminal until rst.
// Optional feature macro: ACC_CPU_MPY_EN enables the signed multiplier used by MPY.
// All memory-port outputs are registered, so they only change on entry to a new transfer
// and hold steady until the matching mem_ack.
module acc_cpu_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] mr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        flags_out,
    output logic              halted
);

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHIFTR = 8'h0D;
    localparam logic [7:0] OP_SHIFTL = 8'h0E;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mr_q, mr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] opr_q, opr_d;
    logic [3:0]        flags_q, flags_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              halted_q, halted_d;

    logic [7:0]        opcode;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W:0]   add_full;
    logic [DATA_W-1:0] sub_res;
    logic              add_v;
    logic              sub_v;
    logic              xfer_done;

    assign opcode    = ir_q[DATA_W-1:DATA_W-8];
    assign op_addr   = ir_q[ADDR_W-1:0];
    assign add_full  = {1'b0, acc_q} + {1'b0, opr_q};
    assign sub_res   = acc_q - opr_q;
    assign add_v     = (acc_q[DATA_W-1] == opr_q[DATA_W-1]) &&
                       (add_full[DATA_W-1] != acc_q[DATA_W-1]);
    assign sub_v     = (acc_q[DATA_W-1] != opr_q[DATA_W-1]) &&
                       (sub_res[DATA_W-1] != acc_q[DATA_W-1]);
    // An ack only counts while our own request is outstanding.
    assign xfer_done = mem_req_q && mem_ack;

`ifdef ACC_CPU_MPY_EN
    logic signed [2*DATA_W-1:0] product;
    assign product = $signed(acc_q) * $signed(opr_q);
`endif

    // {Z,N} of a result word.
    function automatic logic [1:0] zn(input logic [DATA_W-1:0] r);
        zn = {(r == '0), r[DATA_W-1]};
    endfunction

    // Next-state and datapath: every register holds unless its state says otherwise.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        mr_d        = mr_q;
        ir_d        = ir_q;
        opr_d       = opr_q;
        flags_d     = flags_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;

        case (state_q)
            StIdle: begin
                state_d    = StFetch;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_q;
            end
            StFetch: begin
                if (xfer_done) begin
                    ir_d      = mem_rdata;
                    pc_d      = pc_q + ADDR_W'(1);
                    mem_req_d = 1'b0;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR, OP_STORE: begin
                        state_d    = StMem;
                        mem_req_d  = 1'b1;
                        mem_addr_d = op_addr;
                        mem_we_d   = (opcode == OP_STORE);
                        if (opcode == OP_STORE) begin
                            mem_wdata_d = acc_q;
                        end
                    end
                    OP_HALT: begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    default: state_d = StExec;
                endcase
            end
            StMem: begin
                if (xfer_done) begin
                    if (mem_we_q) begin
                        // Store completes here; go straight back to fetching.
                        state_d    = StFetch;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = pc_q;
                    end else begin
                        opr_d     = mem_rdata;
                        mem_req_d = 1'b0;
                        state_d   = StExec;
                    end
                end
            end
            StExec: begin
                case (opcode)
                    OP_LOAD: begin
                        acc_d   = opr_q;
                        flags_d = {zn(opr_q), 2'b00};
                    end
                    OP_ADD: begin
                        acc_d   = add_full[DATA_W-1:0];
                        flags_d = {zn(add_full[DATA_W-1:0]), add_full[DATA_W], add_v};
                    end
                    OP_SUB: begin
                        acc_d   = sub_res;
                        flags_d = {zn(sub_res), (acc_q < opr_q), sub_v};
                    end
                    OP_AND: begin
                        acc_d   = acc_q & opr_q;
                        flags_d = {zn(acc_q & opr_q), 2'b00};
                    end
                    OP_OR: begin
                        acc_d   = acc_q | opr_q;
                        flags_d = {zn(acc_q | opr_q), 2'b00};
                    end
                    OP_NOT: begin
                        acc_d   = ~acc_q;
                        flags_d = {zn(~acc_q), 2'b00};
                    end
                    OP_SHIFTR: begin
                        acc_d   = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
                        flags_d = {zn({acc_q[DATA_W-1], acc_q[DATA_W-1:1]}), 2'b00};
                    end
                    OP_SHIFTL: begin
                        acc_d   = {acc_q[DATA_W-2:0], 1'b0};
                        flags_d = {zn({acc_q[DATA_W-2:0], 1'b0}), acc_q[DATA_W-1], 1'b0};
                    end
                    OP_JMP: pc_d = op_addr;
                    OP_JMPGEZ: begin
                        if (!acc_q[DATA_W-1]) begin
                            pc_d = op_addr;
                        end
                    end
                    OP_MPY: begin
`ifdef ACC_CPU_MPY_EN
                        mr_d    = product[2*DATA_W-1:DATA_W];
                        acc_d   = product[DATA_W-1:0];
                        flags_d = {(product == '0), product[2*DATA_W-1], 2'b00};
`endif
                    end
                    default: ;
                endcase
                state_d    = StFetch;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_d;
            end
            StHalt: begin
                mem_req_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset also drops any outstanding transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            acc_q       <= '0;
            mr_q        <= '0;
            ir_q        <= '0;
            opr_q       <= '0;
            flags_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            mr_q        <= mr_d;
            ir_q        <= ir_d;
            opr_q       <= opr_d;
            flags_q     <= flags_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign acc_out   = acc_q;
    assign mr_out    = mr_q;
    assign pc_out    = pc_q;
    assign flags_out = flags_q;
    assign halted    = halted_q;

endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, 16, data/instruction word width (SHALL be >= ADDR_W+8).
REQ-002 SHALL have parameter ADDR_W, 8, memory address width and PC width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port mem_req  output  1  memory request, held high until mem_ack.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-007 SHALL have port mem_addr  output  ADDR_W  request address.
REQ-008 SHALL have port mem_wdata  output  DATA_W  write data.
REQ-009 SHALL have port mem_rdata  input  DATA_W  read data, valid in the mem_ack cycle.
REQ-010 SHALL have port mem_ack  input  1  one-cycle transfer completion.
REQ-011 SHALL have ports acc_out and mr_out  output  DATA_W  accumulator and multiplier-high register.
REQ-012 SHALL have port pc_out  output  ADDR_W  program counter.
REQ-013 SHALL have port flags_out  output  4  {Z,N,C,V}.
REQ-014 SHALL have port halted  output  1  high in HALT.

Function
REQ-015 Instruction word: opcode = bits [DATA_W-1:DATA_W-8]; operand address = bits [ADDR_W-1:0].
REQ-016 Opcodes: 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 05 JMPGEZ, 06 JMP, 07 HALT, 08 MPY, 0A AND, 0B OR, 0C NOT, 0D SHIFTR (arithmetic), 0E SHIFTL; any other opcode is a NOP.
REQ-017 FSM states: IDLE, FETCH, DECODE, MEM, EXEC, HALT; IDLE lasts exactly one cycle, then FETCH.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack, latch IR and PC <= PC+1 modulo 2^ADDR_W, then DECODE.
REQ-019 DECODE: LOAD/ADD/SUB/MPY/AND/OR/STORE -> MEM; HALT -> HALT; all others -> EXEC.
REQ-020 MEM: mem_req=1, mem_addr=operand address; STORE drives mem_we=1, mem_wdata=ACC and returns to FETCH on mem_ack; reads latch mem_rdata into an operand register on mem_ack, then EXEC.
REQ-021 EXEC: one cycle; performs the operation, updates ACC/MR/PC/flags, then FETCH.
REQ-022 Zero-wait cycle counts: LOAD/ADD/SUB/MPY/AND/OR 4, STORE 3, others 3; each wait cycle of mem_ack adds one.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable from request until mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-024 ADD/SUB: DATA_W-bit modulo result; C = carry out (ADD) or borrow, i.e. ACC < operand unsigned (SUB); V = signed overflow.
REQ-025 Z/N SHALL reflect the new ACC after LOAD, ADD, SUB, AND, OR, NOT, SHIFTR, SHIFTL; C/V SHALL be cleared by all of these except ADD/SUB; SHIFTL SHALL set C to the bit shifted out.
REQ-026 JMP: PC <= operand address; JMPGEZ: PC <= operand address iff ACC[DATA_W-1]=0; flags unchanged.
REQ-027 HALT: mem_req=0, halted=1, all registers frozen until rst.

Reset
REQ-028 rst sampled high SHALL give, next cycle: state IDLE, PC=0, ACC=0, MR=0, IR=0, flags=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-029 rst during any state, including an outstanding request, SHALL abandon that transfer; a mem_ack arriving after rst SHALL be ignored.

Configuration
REQ-030 Macro ACC_CPU_MPY_EN defined: MPY computes the signed 2*DATA_W-bit product ACC*operand; MR <= high half, ACC <= low half; Z = full product zero, N = product sign, C=V=0.
REQ-031 Macro ACC_CPU_MPY_EN undefined: no multiplier is synthesised; MPY still performs its MEM read but leaves ACC, MR and flags unchanged.

Verification (DATA_W=16, ADDR_W=8)
REQ-032 Program LOAD 10h (mem=7), ADD 11h (mem=5), STORE 12h, HALT -> mem[12h]=000Ch, acc_out=000Ch, halted=1, pc_out=04h.
REQ-033 Same program with mem_ack delayed 3 cycles on every request -> identical results; request signals stable throughout; LOAD takes 10 cycles.
REQ-034 ACC=0100h, MPY operand 0300h -> with macro: mr_out=0003h, acc_out=0000h, Z=0; without macro: acc_out=0100h, mr_out=0000h.
REQ-035 ACC=8000h, SUB operand 0001h -> acc_out=7FFFh, V=1, N=0, C=0; a following JMPGEZ 20h -> pc_out=20h.
REQ-036 JMP FFh with 0000h (NOP) at FFh -> next FETCH mem_addr=00h.
REQ-037 rst asserted while in MEM with mem_ack withheld -> next cycle mem_req=0, pc_out=00h, acc_out=0000h; FETCH from 00h two cycles after rst is released.
